// File: rtl/tempo_player_ctrl.sv
// tempo_player_ctrl: beat sequencer with play/pause and four-level tempo.
// Produces the beat index for the music ROM/keyboard module. Beat timing
// is derived from a free-running tick counter on the system clock, with
// the period selected by the current speed level.
module tempo_player_ctrl #(
  parameter int LEN      = 64,
  parameter int BASE_DIV = 4194304
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_1p,
  input  logic        speedup_1p,
  input  logic        speeddown_1p,
  output logic [11:0] ibeat,
  output logic        playing,
  output logic [1:0]  speed,
  output logic        beat_tick,
  output logic        song_wrap
);

  // Counter wide enough for the slowest (0.5x) beat period.
  localparam int CW = $clog2(2 * BASE_DIV);

  localparam logic [0:0] ST_PAUSED  = 1'b0;
  localparam logic [0:0] ST_PLAYING = 1'b1;

  localparam logic [11:0] LAST_BEAT = 12'(LEN - 1);

  logic [0:0]    state_reg, state_next;
  logic [1:0]    speed_reg, speed_next;
  logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [11:0]   ibeat_reg, ibeat_next;
  logic          beat_tick_reg, beat_tick_next;
  logic          song_wrap_reg, song_wrap_next;

  logic          up_ok;
  logic          down_ok;
  logic          terminal;
  logic          is_last;

  // Terminal-count value per speed level: level gi runs at (2*BASE_DIV) >> gi.
  logic [CW-1:0] period_m1 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_period
      localparam int PER = (2 * BASE_DIV) >> gi;
      assign period_m1[gi] = CW'(PER - 1);
    end
  endgenerate

  // Next-state logic: speed requests, beat advance and play/pause toggle.
  always_comb begin
    up_ok          = speedup_1p && !speeddown_1p && (speed_reg != 2'd3);
    down_ok        = speeddown_1p && !speedup_1p && (speed_reg != 2'd0);
    terminal       = (state_reg == ST_PLAYING) && (tick_cnt_reg == period_m1[speed_reg]);
    is_last        = (ibeat_reg == LAST_BEAT);

    speed_next     = speed_reg;
    tick_cnt_next  = tick_cnt_reg;
    ibeat_next     = ibeat_reg;
    state_next     = state_reg;
    beat_tick_next = terminal;
    song_wrap_next = terminal && is_last;

    if (up_ok) begin
      speed_next = speed_reg + 2'd1;
    end else if (down_ok) begin
      speed_next = speed_reg - 2'd1;
    end

    // A beat boundary or an effective speed change restarts the period;
    // otherwise count only while playing (pre-toggle state decides).
    if (terminal || up_ok || down_ok) begin
      tick_cnt_next = '0;
    end else if (state_reg == ST_PLAYING) begin
      tick_cnt_next = tick_cnt_reg + CW'(1);
    end

    if (terminal) begin
      ibeat_next = is_last ? 12'd0 : ibeat_reg + 12'd1;
    end

    if (play_1p) begin
      state_next = (state_reg == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_PAUSED;
      speed_reg     <= 2'd1;
      tick_cnt_reg  <= '0;
      ibeat_reg     <= 12'd0;
      beat_tick_reg <= 1'b0;
      song_wrap_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      speed_reg     <= speed_next;
      tick_cnt_reg  <= tick_cnt_next;
      ibeat_reg     <= ibeat_next;
      beat_tick_reg <= beat_tick_next;
      song_wrap_reg <= song_wrap_next;
    end
  end

  assign ibeat     = ibeat_reg;
  assign playing   = (state_reg == ST_PLAYING);
  assign speed     = speed_reg;
  assign beat_tick = beat_tick_reg;
  assign song_wrap = song_wrap_reg;

endmodule
